// File: rtl/isa_io_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : isa_io_slave_if
// Brief    : ISA I/O-cycle bus and local register-port bundle for
//            isa_io_slave. The slave modport is the FPGA side, the master
//            modport is the ISA host plus local function side.
// Revision : 1.0 - initial release
// ============================================================================
interface isa_io_slave_if #(
  parameter int NUM_WIN = 4,
  parameter int ADDR_W  = 16
);
  // ISA side
  logic [ADDR_W-1:0]  isa_sa;
  logic               isa_bale;
  logic               isa_aen;
  logic               isa_ior_n;
  logic               isa_iow_n;
  logic               isa_sbhe_n;
  logic [15:0]        isa_sd_in;
  logic [15:0]        isa_sd_out;
  logic               isa_sd_oe;
  logic               sd_dir_n;
  logic               iochrdy_low;
  // Local function side
  logic [NUM_WIN-1:0] cs;
  logic [3:0]         offset;
  logic               wr_stb;
  logic [7:0]         wr_data;
  logic               rd_req;
  logic               rd_ack;
  logic [7:0]         rd_data;
  logic               rd_timeout;

  modport slave (
    input  isa_sa, isa_bale, isa_aen, isa_ior_n, isa_iow_n, isa_sbhe_n,
           isa_sd_in, rd_ack, rd_data,
    output isa_sd_out, isa_sd_oe, sd_dir_n, iochrdy_low,
           cs, offset, wr_stb, wr_data, rd_req, rd_timeout
  );

  modport master (
    output isa_sa, isa_bale, isa_aen, isa_ior_n, isa_iow_n, isa_sbhe_n,
           isa_sd_in, rd_ack, rd_data,
    input  isa_sd_out, isa_sd_oe, sd_dir_n, iochrdy_low,
           cs, offset, wr_stb, wr_data, rd_req, rd_timeout
  );
endinterface
`default_nettype wire

// File: rtl/isa_io_slave.sv
`default_nettype none
// ============================================================================
// Module   : isa_io_slave
// Brief    : ISA I/O-cycle front end with NUM_WIN programmable decode
//            windows. Synchronises ISA strobes, latches the address on BALE,
//            issues single-cycle local read/write requests, steers write
//            byte lanes, drives read data and stretches reads with IOCHRDY.
// Revision : 1.0 - initial release
// ============================================================================
module isa_io_slave #(
  parameter int NUM_WIN     = 4,
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_MAX    = 63
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  isa_io_slave_if.slave              bus,
  input  wire logic [NUM_WIN-1:0]    win_en,
  input  wire logic [NUM_WIN*ADDR_W-1:0] win_base,
  input  wire logic [NUM_WIN*4-1:0]  win_size
);

  // Packed layout of the synchronised ISA inputs
  localparam int SW      = ADDR_W + 21;
  localparam int B_SA    = 21;
  localparam int B_BALE  = 20;
  localparam int B_AEN   = 19;
  localparam int B_IOR   = 18;
  localparam int B_IOW   = 17;
  localparam int B_SBHE  = 16;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_HOLD  = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_RD_DRIVE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchroniser chain
  // --------------------------------------------------------------------------
  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_d [SYNC_STAGES];

  // Shift raw ISA inputs through the synchroniser stages
  always_comb begin
    sync_d[0] = {bus.isa_sa, bus.isa_bale, bus.isa_aen, bus.isa_ior_n,
                 bus.isa_iow_n, bus.isa_sbhe_n, bus.isa_sd_in};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser flops; cleared to 0 so a strobe held low through reset
  // never shows up as a falling edge afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  logic [SW-1:0]     sync_s;
  logic [ADDR_W-1:0] sa_s;
  logic              bale_s;
  logic              aen_s;
  logic              ior_n_s;
  logic              iow_n_s;
  logic              sbhe_n_s;
  logic [15:0]       sd_s;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign sa_s     = sync_s[B_SA +: ADDR_W];
  assign bale_s   = sync_s[B_BALE];
  assign aen_s    = sync_s[B_AEN];
  assign ior_n_s  = sync_s[B_IOR];
  assign iow_n_s  = sync_s[B_IOW];
  assign sbhe_n_s = sync_s[B_SBHE];
  assign sd_s     = sync_s[15:0];

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  state_t             state_q,      state_d;
  logic               bale_prev_q,  bale_prev_d;
  logic               ior_prev_q,   ior_prev_d;
  logic               iow_prev_q,   iow_prev_d;
  logic [ADDR_W-1:0]  addr_lat_q,   addr_lat_d;
  logic [7:0]         wait_cnt_q,   wait_cnt_d;
  logic               wr_stb_q,     wr_stb_d;
  logic               rd_req_q,     rd_req_d;
  logic               rd_timeout_q, rd_timeout_d;
  logic [NUM_WIN-1:0] cs_q,         cs_d;
  logic [3:0]         offset_q,     offset_d;
  logic [7:0]         wr_data_q,    wr_data_d;
  logic               iochrdy_q,    iochrdy_d;
  logic               drive_q,      drive_d;
  logic [15:0]        sd_out_q,     sd_out_d;

  logic bale_fall;
  logic ior_fall;
  logic iow_fall;

  assign bale_fall = bale_prev_q & ~bale_s;
  assign ior_fall  = ior_prev_q  & ~ior_n_s;
  assign iow_fall  = iow_prev_q  & ~iow_n_s;

  // Address latch: transparent while BALE is high, captured on its fall
  always_comb begin
    bale_prev_d = bale_s;
    ior_prev_d  = ior_n_s;
    iow_prev_d  = iow_n_s;
    addr_lat_d  = addr_lat_q;
    if (bale_s || bale_fall) begin
      addr_lat_d = sa_s;
    end
  end

  // --------------------------------------------------------------------------
  // Window decode; scanned high to low so the lowest index wins on overlap
  // --------------------------------------------------------------------------
  logic               hit;
  logic [NUM_WIN-1:0] hit_oh;
  logic [3:0]         hit_off;
  logic [3:0]         win_sz;
  logic [ADDR_W-1:0]  win_b;
  logic [3:0]         off_mask;

  // Compare the latched address against each enabled window
  always_comb begin
    hit      = 1'b0;
    hit_oh   = '0;
    hit_off  = 4'h0;
    win_sz   = 4'h0;
    win_b    = '0;
    off_mask = 4'h0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      win_sz   = win_size[i*4 +: 4];
      win_b    = win_base[i*ADDR_W +: ADDR_W];
      off_mask = (win_sz >= 4'd4) ? 4'hF : 4'((5'd1 << win_sz) - 5'd1);
      if (win_en[i] && ((addr_lat_q >> win_sz) == (win_b >> win_sz))) begin
        hit       = 1'b1;
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        hit_off   = addr_lat_q[3:0] & off_mask;
      end
    end
  end

  logic [7:0] lane_byte;
  logic       cycle_ok;

  // High byte only for an odd address with SBHE# asserted
  assign lane_byte = (!sbhe_n_s && addr_lat_q[0]) ? sd_s[15:8] : sd_s[7:0];
  // DMA cycles and misses are ignored entirely
  assign cycle_ok  = hit & ~aen_s;

  // --------------------------------------------------------------------------
  // Cycle FSM next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    wr_stb_d     = 1'b0;
    rd_req_d     = 1'b0;
    rd_timeout_d = 1'b0;
    cs_d         = '0;
    offset_d     = offset_q;
    wr_data_d    = wr_data_q;
    iochrdy_d    = iochrdy_q;
    drive_d      = drive_q;
    sd_out_d     = sd_out_q;
    case (state_q)
      S_IDLE: begin
        iochrdy_d = 1'b0;
        drive_d   = 1'b0;
        // Simultaneous IOR#/IOW# falls are a bus error and are dropped
        if (iow_fall && !ior_fall && cycle_ok) begin
          wr_stb_d  = 1'b1;
          cs_d      = hit_oh;
          offset_d  = hit_off;
          wr_data_d = lane_byte;
          state_d   = S_WR_HOLD;
        end else if (ior_fall && !iow_fall && cycle_ok) begin
          rd_req_d   = 1'b1;
          cs_d       = hit_oh;
          offset_d   = hit_off;
          wait_cnt_d = 8'd0;
          state_d    = S_RD_WAIT;
        end
      end
      S_WR_HOLD: begin
        if (iow_n_s) begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        // A host abort beats a coincident ack so SD is never driven after
        // the host has released IOR#
        if (ior_n_s) begin
          iochrdy_d = 1'b0;
          state_d   = S_IDLE;
        end else if (bus.rd_ack) begin
          sd_out_d  = {bus.rd_data, bus.rd_data};
          iochrdy_d = 1'b0;
          drive_d   = 1'b1;
          state_d   = S_RD_DRIVE;
        end else if (wait_cnt_q == 8'(WAIT_MAX)) begin
          sd_out_d     = 16'hFFFF;
          rd_timeout_d = 1'b1;
          iochrdy_d    = 1'b0;
          drive_d      = 1'b1;
          state_d      = S_RD_DRIVE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          iochrdy_d  = 1'b1;
        end
      end
      S_RD_DRIVE: begin
        if (ior_n_s) begin
          drive_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register FSM state, edge history and all outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bale_prev_q  <= 1'b0;
      ior_prev_q   <= 1'b0;
      iow_prev_q   <= 1'b0;
      addr_lat_q   <= '0;
      wait_cnt_q   <= 8'd0;
      wr_stb_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_timeout_q <= 1'b0;
      cs_q         <= '0;
      offset_q     <= 4'h0;
      wr_data_q    <= 8'h00;
      iochrdy_q    <= 1'b0;
      drive_q      <= 1'b0;
      sd_out_q     <= 16'h0000;
    end else begin
      state_q      <= state_d;
      bale_prev_q  <= bale_prev_d;
      ior_prev_q   <= ior_prev_d;
      iow_prev_q   <= iow_prev_d;
      addr_lat_q   <= addr_lat_d;
      wait_cnt_q   <= wait_cnt_d;
      wr_stb_q     <= wr_stb_d;
      rd_req_q     <= rd_req_d;
      rd_timeout_q <= rd_timeout_d;
      cs_q         <= cs_d;
      offset_q     <= offset_d;
      wr_data_q    <= wr_data_d;
      iochrdy_q    <= iochrdy_d;
      drive_q      <= drive_d;
      sd_out_q     <= sd_out_d;
    end
  end

  // A single drive flop keeps the output enable and direction in lockstep
  assign bus.isa_sd_out  = sd_out_q;
  assign bus.isa_sd_oe   = drive_q;
  assign bus.sd_dir_n    = ~drive_q;
  assign bus.iochrdy_low = iochrdy_q;
  assign bus.cs          = cs_q;
  assign bus.offset      = offset_q;
  assign bus.wr_stb      = wr_stb_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.rd_req      = rd_req_q;
  assign bus.rd_timeout  = rd_timeout_q;

endmodule
`default_nettype wire
